// File: rtl/scalar_execute_pipe.sv
// Scalar execute stage: 1-cycle ALU, fixed-latency signed MUL, optional restoring DIV/REM.
// Define SCALAR_EXEC_DIV_EN to build the divider; otherwise ops 9/10 behave as reserved ops.
module scalar_execute_pipe #(
  parameter int unsigned DATA_W  = 36,
  parameter int unsigned IMM_W   = 25,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [3:0]        i_op,
  input  logic              i_use_imm,
  input  logic [DATA_W-1:0] i_data1,
  input  logic [DATA_W-1:0] i_data2,
  input  logic [IMM_W-1:0]  i_immediate,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_zero,
  output logic              o_sign,
  output logic              o_overflow,
  output logic              o_busy
);
  localparam int unsigned CntMax = (MUL_LAT > DATA_W) ? MUL_LAT : DATA_W;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [3:0]  OpMul  = 4'd8;

  typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;

  state_e              r_state;
  logic [CntW-1:0]     r_cnt;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_zero, r_sign, r_ovf;
  logic [DATA_W-1:0]   r_mul_res;
  logic                r_mul_ovf;

  logic [DATA_W-1:0]   w_imm_sext, w_op2, w_sum, w_diff, w_alu, w_load_data;
  logic                w_alu_ovf, w_sh_big, w_accept, w_load, w_load_ovf, w_mul_ovf, w_is_div_op;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W:0]     w_prod_hi;

  assign w_imm_sext = DATA_W'($signed(i_immediate));
  assign w_op2      = i_use_imm ? w_imm_sext : i_data2;
  assign o_in_ready = (r_state == StIdle) && !i_flush && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_sum      = i_data1 + w_op2;
  assign w_diff     = i_data1 - w_op2;
  assign w_sh_big   = (w_op2 >= DATA_W'(DATA_W));

  // Full-width signed product; overflow when the top DATA_W+1 bits are not a pure sign extension.
  assign w_prod    = $signed({{DATA_W{i_data1[DATA_W-1]}}, i_data1}) *
                     $signed({{DATA_W{w_op2[DATA_W-1]}}, w_op2});
  assign w_prod_hi = w_prod[2*DATA_W-1:DATA_W-1];
  assign w_mul_ovf = (w_prod_hi != '0) && (w_prod_hi != '1);

  always_comb begin
    w_alu     = '0;
    w_alu_ovf = 1'b0;
    case (i_op)
      4'd0: begin
        w_alu     = w_sum;
        w_alu_ovf = (i_data1[DATA_W-1] == w_op2[DATA_W-1]) && (w_sum[DATA_W-1] != i_data1[DATA_W-1]);
      end
      4'd1: begin
        w_alu     = w_diff;
        w_alu_ovf = (i_data1[DATA_W-1] != w_op2[DATA_W-1]) &&
                    (w_diff[DATA_W-1] != i_data1[DATA_W-1]);
      end
      4'd2: w_alu = i_data1 & w_op2;
      4'd3: w_alu = i_data1 | w_op2;
      4'd4: w_alu = i_data1 ^ w_op2;
      4'd5: w_alu = w_sh_big ? '0 : (i_data1 << w_op2);
      4'd6: w_alu = w_sh_big ? '0 : (i_data1 >> w_op2);
      4'd7: w_alu = w_sh_big ? {DATA_W{i_data1[DATA_W-1]}} : $unsigned($signed(i_data1) >>> w_op2);
      default: w_alu = '0;
    endcase
  end

`ifdef SCALAR_EXEC_DIV_EN
  logic [DATA_W-1:0] r_quot, r_rem, r_divisor;
  logic              r_is_rem;
  logic [DATA_W:0]   w_rem_sh;
  logic              w_ge;
  logic [DATA_W-1:0] w_quot_nxt, w_rem_nxt;

  // One restoring step per cycle; a zero divisor naturally yields all-ones / dividend.
  assign w_rem_sh    = {r_rem, r_quot[DATA_W-1]};
  assign w_ge        = (w_rem_sh >= {1'b0, r_divisor});
  assign w_rem_nxt   = w_ge ? (w_rem_sh[DATA_W-1:0] - r_divisor) : w_rem_sh[DATA_W-1:0];
  assign w_quot_nxt  = {r_quot[DATA_W-2:0], w_ge};
  assign w_is_div_op = (i_op == 4'd9) || (i_op == 4'd10);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quot    <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_is_rem  <= 1'b0;
    end else if ((r_state == StIdle) && w_accept && w_is_div_op) begin
      r_quot    <= i_data1;
      r_rem     <= '0;
      r_divisor <= w_op2;
      r_is_rem  <= (i_op == 4'd10);
    end else if (r_state == StDiv) begin
      r_quot <= w_quot_nxt;
      r_rem  <= w_rem_nxt;
    end
  end
`else
  assign w_is_div_op = 1'b0;
`endif

  always_comb begin
    w_load      = 1'b0;
    w_load_data = w_alu;
    w_load_ovf  = w_alu_ovf;
    unique case (r_state)
      StIdle: begin
        if (w_accept && (i_op != OpMul) && !w_is_div_op) begin
          w_load = 1'b1;
        end else if (w_accept && (i_op == OpMul) && (MUL_LAT == 1)) begin
          w_load      = 1'b1;
          w_load_data = w_prod[DATA_W-1:0];
          w_load_ovf  = w_mul_ovf;
        end
      end
      StMul: begin
        if (r_cnt == '0) begin
          w_load      = 1'b1;
          w_load_data = r_mul_res;
          w_load_ovf  = r_mul_ovf;
        end
      end
`ifdef SCALAR_EXEC_DIV_EN
      StDiv: begin
        if (r_cnt == '0) begin
          w_load      = 1'b1;
          w_load_data = r_is_rem ? w_rem_nxt : w_quot_nxt;
          w_load_ovf  = (r_divisor == '0);
        end
      end
`endif
      default: w_load = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
      r_ovf       <= 1'b0;
      r_mul_res   <= '0;
      r_mul_ovf   <= 1'b0;
    end else if (i_flush) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_data      <= w_load_data;
        r_zero      <= (w_load_data == '0);
        r_sign      <= w_load_data[DATA_W-1];
        r_ovf       <= w_load_ovf;
      end else if (i_out_ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (w_accept && (i_op == OpMul) && (MUL_LAT > 1)) begin
            r_mul_res <= w_prod[DATA_W-1:0];
            r_mul_ovf <= w_mul_ovf;
            r_cnt     <= CntW'(MUL_LAT - 2);
            r_state   <= StMul;
`ifdef SCALAR_EXEC_DIV_EN
          end else if (w_accept && w_is_div_op) begin
            r_cnt   <= CntW'(DATA_W - 1);
            r_state <= StDiv;
`endif
          end
        end
        StMul: begin
          if (r_cnt == '0) r_state <= StIdle;
          else r_cnt <= r_cnt - CntW'(1);
        end
`ifdef SCALAR_EXEC_DIV_EN
        StDiv: begin
          if (r_cnt == '0) r_state <= StIdle;
          else r_cnt <= r_cnt - CntW'(1);
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_data_out  = r_data;
  assign o_zero      = r_zero;
  assign o_sign      = r_sign;
  assign o_overflow  = r_ovf;
  assign o_busy      = (r_state != StIdle);
endmodule

// File: tb/tb_scalar_execute_pipe.sv
// Bench for scalar_execute_pipe: per-cycle comparison against a latency/queue model built from
// plain arithmetic, plus directed literal cases. Honours SCALAR_EXEC_DIV_EN like the design.
`timescale 1ns/1ps
module tb_scalar_execute_pipe;
  localparam int DW = 36;
  localparam int IW = 25;
  localparam int ML = 3;
  localparam longint MAXP = 64'sh7_FFFF_FFFF;
  localparam longint MINN = -64'sh8_0000_0000;

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, use_imm = 1'b0, out_ready = 1'b1;
  logic [3:0]    op = '0;
  logic [DW-1:0] data1 = '0, data2 = '0;
  logic [IW-1:0] imm = '0;
  logic          in_ready, out_valid, zero, sign, overflow, busy;
  logic [DW-1:0] data_out;

  scalar_execute_pipe #(.DATA_W(DW), .IMM_W(IW), .MUL_LAT(ML)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_op(op), .i_use_imm(use_imm), .i_data1(data1), .i_data2(data2), .i_immediate(imm),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_data_out(data_out), .o_zero(zero),
    .o_sign(sign), .o_overflow(overflow), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: visible result register plus at most one in-flight op with cycles remaining.
  bit            m_valid, m_zero, m_sign, m_ovf, m_povf, last_acc;
  logic [DW-1:0] m_data, m_pdata;
  int            m_infl;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] opnd2();
    return use_imm ? {{(DW-IW){imm[IW-1]}}, imm} : data2;
  endfunction

  function automatic bit m_in_ready();
    return (m_infl == 0) && !flush && (!m_valid || out_ready);
  endfunction

  task automatic ref_op(input logic [3:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [DW-1:0] r, output bit v, output int l);
    longint sa, sb, s;
    logic signed [2*DW-1:0] pa, pb, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; v = 1'b0; l = 1;
    case (o)
      4'd0: begin s = sa + sb; r = s[DW-1:0]; v = (s > MAXP) || (s < MINN); end
      4'd1: begin s = sa - sb; r = s[DW-1:0]; v = (s > MAXP) || (s < MINN); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (b >= 36) ? '0 : (a << b);
      4'd6: r = (b >= 36) ? '0 : (a >> b);
      4'd7: begin s = sa >>> ((b >= 36) ? 63 : int'(b[5:0])); r = s[DW-1:0]; end
      4'd8: begin
        pa = sa; pb = sb; p = pa * pb;
        r = p[DW-1:0]; v = (p > MAXP) || (p < MINN); l = ML;
      end
`ifdef SCALAR_EXEC_DIV_EN
      4'd9:  begin r = (b == 0) ? '1 : a / b; v = (b == 0); l = DW + 1; end
      4'd10: begin r = (b == 0) ? a : a % b;  v = (b == 0); l = DW + 1; end
`endif
      default: ;
    endcase
  endtask

  task automatic m_load(input logic [DW-1:0] r, input bit v);
    m_valid = 1'b1; m_data = r; m_zero = (r == 0); m_sign = r[DW-1]; m_ovf = v;
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_zero = 0; m_sign = 0; m_ovf = 0; m_infl = 0;
    m_pdata = '0; m_povf = 0;
  endtask

  task automatic model_step();
    bit rdy, v;
    logic [DW-1:0] r;
    int l;
    last_acc = 1'b0;
    if (rst) return;
    rdy = m_in_ready();
    if (flush) begin m_valid = 0; m_infl = 0; return; end
    if (m_valid && out_ready) m_valid = 0;
    if (m_infl > 0) begin
      m_infl--;
      if (m_infl == 0) m_load(m_pdata, m_povf);
    end
    if (in_valid && rdy) begin
      last_acc = 1'b1;
      ref_op(op, data1, opnd2(), r, v, l);
      if (l == 1) m_load(r, v);
      else begin m_pdata = r; m_povf = v; m_infl = l - 1; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (cmp_en) begin
        chk("out_valid", out_valid, m_valid);
        chk("data_out", data_out, m_data);
        chk("zero", zero, m_zero);
        chk("sign", sign, m_sign);
        chk("overflow", overflow, m_ovf);
        chk("busy", busy, m_infl > 0);
        chk("in_ready", in_ready, m_in_ready());
      end
    end
  end

  task automatic directed(input string name, input logic [3:0] o, input bit ui,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] im,
                          input logic [DW-1:0] ed, input bit eo, input int elat);
    int lat, guard;
    op = o; use_imm = ui; data1 = a; data2 = b; imm = im;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    guard = 0;
    do begin tick(); guard++; end while (!last_acc && guard < 100);
    in_valid = 1'b0;
    chk({name, "_acc"}, last_acc, 1);
    if (elat > 1) begin
      chk({name, "_busy"}, busy, 1);
      chk({name, "_in_ready"}, in_ready, 0);
    end
    lat = 1;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    chk({name, "_lat"}, lat, elat);
    chk({name, "_data"}, data_out, ed);
    chk({name, "_ovf"}, overflow, eo);
    chk({name, "_model"}, m_data, ed);
    tick();
  endtask

  function automatic logic [DW-1:0] rnd_opnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 36'h7_FFFF_FFFF;
      2: return 36'h8_0000_0000;
      3: return '1;
      4: return DW'($urandom_range(0, 45));
      default: return t[DW-1:0];
    endcase
  endfunction

  initial begin
    int cnt;
    do_reset();
    cmp_en = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    directed("add_max", 4'd0, 0, 36'h7_FFFF_FFFF, 36'h1, '0, 36'h8_0000_0000, 1, 1);
    chk("add_max_sign", sign, 1);
    directed("sub_min", 4'd1, 0, 36'h8_0000_0000, 36'h1, '0, 36'h7_FFFF_FFFF, 1, 1);
    directed("add_imm", 4'd0, 1, 36'd5, 36'h0, 25'h1FF_FFFF, 36'd4, 0, 1);
    directed("sra_40", 4'd7, 0, 36'h8_0000_0000, 36'd40, '0, 36'hF_FFFF_FFFF, 0, 1);
    directed("sll_36", 4'd5, 0, 36'h1, 36'd36, '0, 36'h0, 0, 1);
    chk("sll_36_zero", zero, 1);
    directed("mul_neg", 4'd8, 0, 36'd3, 36'hF_FFFF_FFFE, '0, 36'hF_FFFF_FFFA, 0, 3);
    directed("mul_ovf", 4'd8, 0, 36'h4_0000_0000, 36'd4, '0, 36'h0, 1, 3);
    directed("reserved", 4'd12, 0, 36'd5, 36'd6, '0, 36'h0, 0, 1);
    chk("reserved_zero", zero, 1);
`ifdef SCALAR_EXEC_DIV_EN
    directed("div", 4'd9, 0, 36'd100, 36'd7, '0, 36'd14, 0, 37);
    directed("rem", 4'd10, 0, 36'd100, 36'd7, '0, 36'd2, 0, 37);
    directed("div0", 4'd9, 0, 36'd9, 36'd0, '0, 36'hF_FFFF_FFFF, 1, 37);
    directed("rem0", 4'd10, 0, 36'd9, 36'd0, '0, 36'd9, 1, 37);
`else
    directed("div_off", 4'd9, 0, 36'd100, 36'd7, '0, 36'h0, 0, 1);
`endif

    // Backpressure: result held for five cycles while a new op waits.
    op = 4'd0; use_imm = 0; data1 = 36'd10; data2 = 36'd20; in_valid = 1; out_ready = 0;
    tick();
    chk("bp_acc", last_acc, 1);
    op = 4'd4; data1 = 36'd5; data2 = 36'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_data", data_out, 36'd30);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_blocked", last_acc, 0);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    chk("bp_release_acc", last_acc, 1);
    chk("bp_next_data", data_out, 36'd6);

    cnt = 0;
    op = 4'd0; data2 = 36'd100;
    for (int i = 0; i < 10; i++) begin
      data1 = DW'(i);
      tick();
      if (out_valid) cnt++;
      chk("stream_data", data_out, DW'(i + 100));
    end
    in_valid = 0;
    tick();
    chk("stream_count", cnt, 10);
    chk("stream_tail", out_valid, 0);

    op = 4'd8; data1 = 36'd7; data2 = 36'd9; in_valid = 1;
    tick();
    chk("fmul_acc", last_acc, 1);
    in_valid = 0; flush = 1;
    tick();
    flush = 0;
    #1;
    chk("fmul_valid", out_valid, 0);
    chk("fmul_busy", busy, 0);
    chk("fmul_in_ready", in_ready, 1);
    repeat (4) begin tick(); chk("fmul_dropped", out_valid, 0); end

`ifdef SCALAR_EXEC_DIV_EN
    op = 4'd9; data1 = 36'd1000; data2 = 36'd3; in_valid = 1;
    tick();
    chk("fdiv_acc", last_acc, 1);
    in_valid = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    #1;
    chk("fdiv_valid", out_valid, 0);
    chk("fdiv_in_ready", in_ready, 1);
    repeat (40) begin tick(); chk("fdiv_dropped", out_valid, 0); end
`endif

    directed("pre_rst", 4'd1, 0, 36'd1, 36'd2, '0, 36'hF_FFFF_FFFF, 0, 1);
    op = 4'd8; data1 = 36'd5; data2 = 36'd5; in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    rst = 1; model_reset();
    #1;
    chk("rmul_valid", out_valid, 0);
    chk("rmul_data", data_out, 0);
    chk("rmul_sign", sign, 0);
    chk("rmul_busy", busy, 0);
    tick();
    rst = 0;
    repeat (4) begin tick(); chk("rmul_no_partial", out_valid, 0); end

    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 49) == 0);
      op        = 4'($urandom_range(0, 15));
      use_imm   = ($urandom_range(0, 3) == 0);
      data1     = rnd_opnd();
      data2     = rnd_opnd();
      imm       = IW'($urandom());
      tick();
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    in_valid = 0; flush = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
